// File: rtl/booth_pair_multiplier.sv
// booth_pair_multiplier: sequential signed 32x32 multiplier using radix-4
// bit-pair (modified Booth) recoding, one recoded digit per clock.
// The 64-bit product is presented on hi/lo with a start/busy/done handshake.
module booth_pair_multiplier (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType    state;
    logic [31:0] mReg;
    logic [31:0] qReg;
    logic [63:0] acc;
    logic [3:0]  count;

    // Combinational digit recoding and partial-product formation
    logic [32:0] qExt;
    logic [4:0]  shiftAmt;
    logic [2:0]  triplet;
    logic [33:0] mExt;
    logic [33:0] pp;
    logic [63:0] ppExt;
    logic [63:0] accNext;

    // Select the current bit-pair triplet and form the weighted partial product
    always_comb begin
        qExt     = {qReg, 1'b0};          // bit 0 plays the role of Q[-1] = 0
        shiftAmt = {count, 1'b0};
        triplet  = qExt[shiftAmt +: 3];
        mExt     = {{2{mReg[31]}}, mReg};
        pp       = '0;
        case (triplet)
            3'b001, 3'b010: pp = mExt;
            3'b011:         pp = mExt << 1;
            3'b100:         pp = ~(mExt << 1) + 34'd1;
            3'b101, 3'b110: pp = ~mExt + 34'd1;
            default:        pp = '0;
        endcase
        ppExt   = {{30{pp[33]}}, pp};
        accNext = acc + (ppExt << shiftAmt);
    end

    // Control FSM, accumulator and registered handshake/result outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            mReg  <= '0;
            qReg  <= '0;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        mReg  <= multiplicand;
                        qReg  <= multiplier;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= accNext;
                    if (count == 4'd15) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= accNext[63:32];
                        lo    <= accNext[31:0];
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
